// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//
// Multi-cycle add/subtract controller that time-shares a single 4-bit
// combinational parallel_adder. Wide operands are processed one nibble per
// clock, least-significant nibble first, with the carry registered between
// nibbles. Subtraction is A + ~B + 1: B is inverted when latched and the
// initial carry-in is set to 1.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset (priority over everything)
//   start     request, accepted only while idle
//   sub       0 = A+B, 1 = A-B, sampled with start
//   op_a      operand A (W = 4*NIBBLES bits), sampled with start
//   op_b      operand B (W bits), sampled with start
//   busy      high while an accepted operation is running or completing
//   done      one-cycle completion pulse
//   result    sum/difference, held until the next completion
//   carry     final adder carry-out (for subtract, 1 = no borrow)
//   overflow  signed two's-complement overflow of the operation
//   dbg_state FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: a request is taken on any rising edge where start=1 and the
// block is idle (busy=0). Requests while busy=1 are dropped, never queued;
// the requester must hold start (and operands) until it sees busy rise.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry,
  output logic                   overflow,
  output logic [1:0]             dbg_state
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     result_q, result_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_s;
  logic             add_co;

  // Nibble select feeding the shared adder. Written as a compare-per-slice
  // mux so the select width stays exactly IDX_W bits.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a = a_q[4*i +: 4];
        add_b = b_q[4*i +: 4];
      end
    end
  end

  parallel_adder u_adder (
    .A     (add_a),
    .B     (add_b),
    .C_in  (cy_q),
    .S     (add_s),
    .C_out (add_co)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    cy_d     = cy_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          cy_d    = sub;           // the +1 of A + ~B + 1
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            work_d[4*i +: 4] = add_s;
          end
        end
        cy_d = add_co;
        if (idx_q == LAST_IDX) begin
          // work_d already holds the current top-nibble sum here.
          // idx wraps to 0 so it never points past the operand for
          // non-power-of-two NIBBLES; it is reloaded on the next start.
          idx_d    = '0;
          state_d  = ST_DONE;
          result_d = work_d;
          carry_d  = add_co;
          // b_q is already inverted for subtract, so one rule covers both.
          ovf_d    = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  // All outputs decode registered state only.
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// parallel_adder
//
// 4-bit combinational ripple adder shared by the sequencer.
//   A, B   4-bit addends
//   C_in   carry in
//   S      4-bit sum
//   C_out  carry out
module parallel_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);

  assign {C_out, S} = {1'b0, A} + {1'b0, B} + {4'b0000, C_in};

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle add/subtract controller that time-shares one 4-bit `parallel_adder` instance (ports `A`, `B`, `C_in`, `S`, `C_out`, combinational) to process wide operands one nibble per clock, least-significant nibble first. Carry is registered between nibbles. The block sits between a requesting datapath and the shared adder. It owns the adder's inputs completely: it sequences operand slices, injects the carry and handles subtract by operand inversion.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES, must be ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE
- `sub`  in  1  0 = A+B, 1 = A−B; sampled with `start`
- `op_a`  in  W  operand A; sampled with `start`
- `op_b`  in  W  operand B; sampled with `start`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `result`  out  W  sum/difference; held until next completion
- `carry`  out  1  final adder `C_out`; for subtract, 1 = no borrow
- `overflow`  out  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Nibble index `idx` is ceil(log2(NIBBLES)) bits wide.
- IDLE with `start`=1:
  - latch `a_reg`=`op_a`, and `b_reg`=`op_b` (sub=0) or ~`op_b` (sub=1)
  - carry register `cy`=`sub`, `idx`=0
  - go to RUN
- IDLE with `start`=0: stay in IDLE.
- Adder hookup at all times: `A`=`a_reg[4*idx+:4]`, `B`=`b_reg[4*idx+:4]`, `C_in`=`cy`.
- RUN, each cycle:
  - `work[4*idx+:4]` <= `S`
  - `cy` <= `C_out`
  - `idx` <= `idx`+1
  - When `idx`==NIBBLES−1, also go to DONE and capture:
    - `carry` <= `C_out`
    - `result` <= `work` with the top nibble replaced by the current `S`
    - `overflow` <= (a_reg[W−1] == b_reg[W−1]) && (S[3] != a_reg[W−1]), using the inverted b_reg for subtract
- DONE: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- `start` during RUN or DONE is ignored: no queueing, and operands are not re-sampled.
- `result`, `carry` and `overflow` change only on the DONE-entry edge. Between completions they hold their values, including while a new operation runs.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1.
- NIBBLES=1 is out of scope.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carry`=0, `overflow`=0, `idx`=0, `cy`=0.
- `rst` has priority over every other input, in every state.
  - Reset during RUN aborts the operation: no `done`, and outputs return to reset values.
- Latency: `start` sampled at edge 0 gives RUN for edges 1..NIBBLES. Outputs update and `done`/DONE appear after edge NIBBLES; `done` is high until edge NIBBLES+1.
- `busy` rises after edge 0 and falls after edge NIBBLES+1.
- Maximum throughput: one operation per NIBBLES+2 cycles. With `start` held high, requests are accepted at edges 0, NIBBLES+2, 2(NIBBLES+2), …
- `done` is registered, driven from state. There is no combinational path from inputs to outputs.
- Critical path: register → 4-bit adder → `cy`/`work`. The path does not depend on W.

## Test plan
All scenarios use NIBBLES=4.
- Carry-free add: `op_a`=0x1234, `op_b`=0x4321, `sub`=0 → after 5 edges `done`=1, `result`=0x5555, `carry`=0, `overflow`=0. `busy` is high for exactly 5 cycles.
- Full ripple across nibbles: 0xFFFF + 0x0001 → `result`=0x0000, `carry`=1, `overflow`=0. Also check 0x7FFF + 0x0001 → 0x8000, `carry`=0, `overflow`=1.
- Subtract:
  - 0x0005 − 0x0007 → 0xFFFE, `carry`=0 (borrow), `overflow`=0
  - 0x8000 − 0x0001 → 0x7FFF, `carry`=1, `overflow`=1
  - 0x1234 − 0x1234 → 0x0000, `carry`=1
- Busy rejection and back-to-back:
  - Hold `start`=1 and change `op_a`/`op_b` mid-RUN. The first result must reflect the edge-0 operands.
  - The second acceptance occurs at edge 6, and `done` pulses after edges 4 and 10.
  - `result` holds 0x5555 (from the 0x1234+0x4321 request) through the second RUN.
- Reset mid-operation: assert `rst` for one cycle after edge 2 of 0xFFFF+0x0001 → `busy`=0, `result`=0, `carry`=0, and `done` never pulses. A subsequent `start` with 0x0001+0x0001 gives 0x0002 with `carry`=0, showing no stale `cy`.
- Parameter sweep: NIBBLES=2 and 8 with random operands (1000 each) against the W-bit reference model. Check `result`, `carry` and `overflow`, and that `done` falls exactly NIBBLES+1 edges after acceptance.
